// File: rtl/irq_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : irq_ctrl_pkg
//  Description : Shared definitions for the interrupt controller: register
//                byte offsets on the system bus and the service FSM states.
//  Revision    : 1.0  initial release
// ============================================================================
package irq_ctrl_pkg;

   // Register byte offsets within the block
   localparam logic [31:0] IRQ_PENDING_ADDR = 32'h0000_0000;
   localparam logic [31:0] IRQ_MASK_ADDR    = 32'h0000_0004;
   localparam logic [31:0] IRQ_ACTIVE_ADDR  = 32'h0000_0008;
   localparam logic [31:0] IRQ_SWSET_ADDR   = 32'h0000_000C;

   // Service FSM states
   typedef enum logic [0:0] {
      IDLE    = 1'b0,
      SERVICE = 1'b1
   } irq_state_t;

endpackage
`default_nettype wire

// File: rtl/irq_prio_enc.sv
`default_nettype none
// ============================================================================
//  Module      : irq_prio_enc
//  Description : Combinational fixed-priority encoder. Reports whether any
//                request bit is set and the index of the lowest set bit.
//  Ports       : i_req   [N_IRQ]  request vector (already masked)
//                o_valid [1]      at least one request set
//                o_index [ID_W]   lowest set index (0 when none)
//  Revision    : 1.0  initial release
// ============================================================================
module irq_prio_enc #(
   parameter int N_IRQ = 16,
   parameter int ID_W  = 5
) (
   input  logic [N_IRQ-1:0] i_req,
   output logic             o_valid,
   output logic [ID_W-1:0]  o_index
);

   // Scan from the top down so the last hit, i.e. the lowest index, wins.
   always_comb begin
      o_valid = 1'b0;
      o_index = '0;
      for (int i = N_IRQ - 1; i >= 0; i--) begin
         if (i_req[i]) begin
            o_valid = 1'b1;
            o_index = ID_W'(i);
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/irq_controller.sv
`default_nettype none
// ============================================================================
//  Module      : irq_controller
//  Description : Interrupt controller. Latches rising edges of peripheral
//                level interrupts as pending bits, masks them, picks the
//                lowest-index source and runs a request/return handshake with
//                the core. Configured over the system-bus register interface.
//  Ports       : clk_i, rst_i (async, active-high)
//                req_i, write_enable_i, addr_i, write_data_i  bus request
//                read_data_o, ready_o                         bus response
//                irq_lines_i [N_IRQ]  level interrupt inputs
//                irq_req_o            request to core
//                irq_ret_i            return-from-handler pulse from core
//                irq_id_o    [ID_W]   index of the source in service
//                irq_ack_o   [N_IRQ]  one-hot acknowledge to the source
//  Revision    : 1.0  initial release
// ============================================================================
module irq_controller
   import irq_ctrl_pkg::*;
#(
   parameter int N_IRQ = 16,
   parameter int ID_W  = 5
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              req_i,
   input  logic              write_enable_i,
   input  logic [31:0]       addr_i,
   input  logic [31:0]       write_data_i,
   output logic [31:0]       read_data_o,
   output logic              ready_o,
   input  logic [N_IRQ-1:0]  irq_lines_i,
   output logic              irq_req_o,
   input  logic              irq_ret_i,
   output logic [ID_W-1:0]   irq_id_o,
   output logic [N_IRQ-1:0]  irq_ack_o
);

   localparam logic [N_IRQ-1:0] c_one = N_IRQ'(1);

   // ---------------------------------------------------------------------
   // Registers
   // ---------------------------------------------------------------------
   irq_state_t        r_state;
   logic [N_IRQ-1:0]  r_hist;
   logic [N_IRQ-1:0]  r_pending;
   logic [N_IRQ-1:0]  r_mask;
   logic [ID_W-1:0]   r_id;
   logic [N_IRQ-1:0]  r_ack;
   logic              r_ready;
   logic [31:0]       r_rdata;

   // ---------------------------------------------------------------------
   // Combinational signals
   // ---------------------------------------------------------------------
   irq_state_t        w_state_nxt;
   logic              w_capture;
   logic [N_IRQ-1:0]  w_ack_nxt;
   logic              w_enc_valid;
   logic [ID_W-1:0]   w_enc_idx;
   logic              w_bus_we;
   logic [N_IRQ-1:0]  w_wdata;
   logic [N_IRQ-1:0]  w_set;
   logic [N_IRQ-1:0]  w_clr;
   logic [N_IRQ-1:0]  w_w1c;
   logic [N_IRQ-1:0]  w_swset;
   logic              w_mask_we;
   logic [31:0]       w_rdata;
   logic              w_unused_wdata;

   // Write data above N_IRQ is dropped; bits above are deliberately ignored.
   assign w_wdata        = write_data_i[N_IRQ-1:0];
   assign w_unused_wdata = ^write_data_i;

   assign w_bus_we  = req_i & write_enable_i;
   assign w_mask_we = w_bus_we & (addr_i == IRQ_MASK_ADDR);
   assign w_w1c     = (w_bus_we && addr_i == IRQ_PENDING_ADDR) ? w_wdata : '0;
   assign w_swset   = (w_bus_we && addr_i == IRQ_SWSET_ADDR)   ? w_wdata : '0;

   // Set sources: line rising edge or software set. Clear sources: W1C or the
   // FSM taking the source into service. Set has priority over clear.
   assign w_set = (irq_lines_i & ~r_hist) | w_swset;
   assign w_clr = w_w1c | (w_capture ? (c_one << w_enc_idx) : '0);

   irq_prio_enc #(
      .N_IRQ (N_IRQ),
      .ID_W  (ID_W)
   ) u_prio_enc (
      .i_req   (r_pending & r_mask),
      .o_valid (w_enc_valid),
      .o_index (w_enc_idx)
   );

   // ---------------------------------------------------------------------
   // Service FSM: state register
   // ---------------------------------------------------------------------
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Service FSM: next state and control. Returning to IDLE always costs at
   // least one IDLE cycle before the next capture.
   always_comb begin
      w_state_nxt = r_state;
      w_capture   = 1'b0;
      w_ack_nxt   = '0;
      case (r_state)
         IDLE: begin
            if (w_enc_valid) begin
               w_capture   = 1'b1;
               w_state_nxt = SERVICE;
            end
         end
         SERVICE: begin
            if (irq_ret_i) begin
               w_ack_nxt   = c_one << r_id;
               w_state_nxt = IDLE;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // ---------------------------------------------------------------------
   // Read mux (read accesses only; everything else returns 0)
   // ---------------------------------------------------------------------
   always_comb begin
      w_rdata = '0;
      if (req_i && !write_enable_i) begin
         case (addr_i)
            IRQ_PENDING_ADDR: w_rdata = 32'(r_pending);
            IRQ_MASK_ADDR:    w_rdata = 32'(r_mask);
            IRQ_ACTIVE_ADDR:  w_rdata = {(r_state == SERVICE), 31'(r_id)};
            default:          w_rdata = '0;
         endcase
      end
   end

   // ---------------------------------------------------------------------
   // Datapath registers
   // ---------------------------------------------------------------------
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_hist    <= '0;
         r_pending <= '0;
         r_mask    <= '0;
         r_id      <= '0;
         r_ack     <= '0;
         r_ready   <= 1'b0;
         r_rdata   <= '0;
      end else begin
         r_hist    <= irq_lines_i;
         r_pending <= (r_pending & ~w_clr) | w_set;
         if (w_mask_we) begin
            r_mask <= w_wdata;
         end
         if (w_capture) begin
            r_id <= w_enc_idx;
         end
         r_ack     <= w_ack_nxt;
         r_ready   <= req_i;
         r_rdata   <= w_rdata;
      end
   end

   // irq_req_o is decoded straight from the state flop so that an
   // asynchronous reset drops it immediately.
   assign irq_req_o   = (r_state == SERVICE);
   assign irq_id_o    = r_id;
   assign irq_ack_o   = r_ack;
   assign ready_o     = r_ready;
   assign read_data_o = r_rdata;

endmodule
`default_nettype wire

// File: tb/tb_irq_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_irq_controller
//  Description : Self-checking bench for irq_controller: a table of register
//                accesses, hand-written handshake sequences, and a randomized
//                run compared against a rule-level reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_irq_controller;

   localparam int N  = 16;
   localparam int IW = 5;

   logic          clk = 1'b0;
   logic          rst;
   logic          req;
   logic          we;
   logic [31:0]   addr;
   logic [31:0]   wdata;
   logic [31:0]   rdata;
   logic          ready;
   logic [N-1:0]  lines;
   logic          irq_req;
   logic          ret;
   logic [IW-1:0] id;
   logic [N-1:0]  ack;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   irq_controller #(.N_IRQ(N), .ID_W(IW)) dut (
      .clk_i          (clk),
      .rst_i          (rst),
      .req_i          (req),
      .write_enable_i (we),
      .addr_i         (addr),
      .write_data_i   (wdata),
      .read_data_o    (rdata),
      .ready_o        (ready),
      .irq_lines_i    (lines),
      .irq_req_o      (irq_req),
      .irq_ret_i      (ret),
      .irq_id_o       (id),
      .irq_ack_o      (ack)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic bus(input logic w, input logic [31:0] a, input logic [31:0] d,
                      output logic [31:0] rd, output logic rdy);
      @(negedge clk);
      req = 1'b1; we = w; addr = a; wdata = d;
      @(posedge clk); #1;
      rd = rdata; rdy = ready;
      @(negedge clk);
      req = 1'b0; we = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic wait_req(input int budget, input string name);
      int k = 0;
      while (irq_req !== 1'b1 && k < budget) begin
         @(posedge clk); #1;
         k++;
      end
      check(name, 32'(irq_req), 32'd1);
   endtask

   task automatic ret_pulse();
      @(negedge clk); ret = 1'b1;
      @(posedge clk); #1;
   endtask

   // ---------------------------------------------------------------------
   // Table of register accesses (applied from reset, all interrupts quiet)
   // ---------------------------------------------------------------------
   typedef struct {
      logic        w;
      logic [31:0] a;
      logic [31:0] d;
      logic [31:0] exp;
   } vec_t;

   vec_t tbl [16];

   // ---------------------------------------------------------------------
   // Reference model state (rule level)
   // ---------------------------------------------------------------------
   logic [N-1:0] m_pend, m_mask, m_hist;
   bit           m_busy;
   int           m_id;

   initial begin
      logic [31:0] rd;
      logic        rdy;
      int          acks;

      rst = 1'b1; req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
      lines = '0; ret = 1'b0;

      tbl[0]  = '{1'b0, 32'h00, 32'h0,         32'h0};
      tbl[1]  = '{1'b0, 32'h04, 32'h0,         32'h0};
      tbl[2]  = '{1'b1, 32'h04, 32'hFFFF_0028, 32'h0};
      tbl[3]  = '{1'b0, 32'h04, 32'h0,         32'h0000_0028};
      tbl[4]  = '{1'b0, 32'h08, 32'h0,         32'h0};
      tbl[5]  = '{1'b0, 32'h0C, 32'h0,         32'h0};
      tbl[6]  = '{1'b1, 32'h10, 32'hFFFF_FFFF, 32'h0};
      tbl[7]  = '{1'b0, 32'h10, 32'h0,         32'h0};
      tbl[8]  = '{1'b0, 32'h04, 32'h0,         32'h0000_0028};
      tbl[9]  = '{1'b1, 32'h04, 32'h0,         32'h0};
      tbl[10] = '{1'b1, 32'h0C, 32'hFFFF_0300, 32'h0};
      tbl[11] = '{1'b0, 32'h00, 32'h0,         32'h0000_0300};
      tbl[12] = '{1'b1, 32'h00, 32'h0000_0100, 32'h0};
      tbl[13] = '{1'b0, 32'h00, 32'h0,         32'h0000_0200};
      tbl[14] = '{1'b1, 32'h00, 32'hFFFF_FFFF, 32'h0};
      tbl[15] = '{1'b0, 32'h00, 32'h0,         32'h0};

      // Reset state
      do_reset();
      @(posedge clk); #1;
      check("rst_outputs", {ready, irq_req, id, ack}, 32'h0);
      check("rst_rdata", rdata, 32'h0);

      for (int i = 0; i < 16; i++) begin
         bus(tbl[i].w, tbl[i].a, tbl[i].d, rd, rdy);
         check($sformatf("tbl%0d_ready", i), 32'(rdy), 32'd1);
         if (!tbl[i].w) check($sformatf("tbl%0d_rdata", i), rd, tbl[i].exp);
      end
      @(posedge clk); #1;
      check("ready_drops", {ready, rdata[30:0]}, 32'h0);

      // --- A: basic service on source 0 ---
      do_reset();
      bus(1'b1, 32'h04, 32'h1, rd, rdy);
      @(negedge clk); lines[0] = 1'b1;
      @(posedge clk); #1;
      check("A_req_not_yet", 32'(irq_req), 32'd0);
      @(negedge clk); req = 1'b1; we = 1'b0; addr = 32'h00;
      @(posedge clk); #1;
      check("A_pending_seen", rdata, 32'h1);
      check("A_req_id", {irq_req, id}, {26'd0, 1'b1, 5'd0});
      @(negedge clk); req = 1'b0;
      bus(1'b0, 32'h00, 32'h0, rd, rdy);
      check("A_pending_cleared", rd, 32'h0);
      ret_pulse();
      check("A_ack", {irq_req, ack}, 32'h0001);
      @(negedge clk); ret = 1'b0;
      @(posedge clk); #1;
      check("A_ack_one_cycle", 32'(ack), 32'h0);
      @(negedge clk); lines[0] = 1'b0;

      // --- B: masked pending, then priority 3 before 5 ---
      bus(1'b1, 32'h04, 32'h0, rd, rdy);
      @(negedge clk); lines[3] = 1'b1; lines[5] = 1'b1;
      repeat (2) @(posedge clk);
      bus(1'b0, 32'h00, 32'h0, rd, rdy);
      check("B_pending", rd, 32'h28);
      check("B_no_req", 32'(irq_req), 32'd0);
      bus(1'b1, 32'h04, 32'h28, rd, rdy);
      wait_req(10, "B_req3");
      check("B_id3", 32'(id), 32'd3);
      ret_pulse();
      check("B_ack3", {irq_req, ack}, 32'h0008);
      @(negedge clk); ret = 1'b0;
      @(posedge clk); #1;
      check("B_req5", {irq_req, id, ack}, {10'd0, 1'b1, 5'd5, 16'h0});
      ret_pulse();
      check("B_ack5", {irq_req, ack}, 32'h0020);
      @(negedge clk); ret = 1'b0; lines[3] = 1'b0; lines[5] = 1'b0;

      // --- C: level held high gives one service ---
      bus(1'b1, 32'h04, 32'h4, rd, rdy);
      acks = 0;
      @(negedge clk); lines[2] = 1'b1;
      for (int c = 0; c < 60; c++) begin
         @(negedge clk);
         ret = irq_req;
         if (c == 50) lines[2] = 1'b0;
         @(posedge clk); #1;
         if (ack[2]) acks++;
      end
      @(negedge clk); ret = 1'b0;
      check("C_one_ack", 32'(acks), 32'd1);

      // --- D: edge beats W1C on the same cycle ---
      bus(1'b1, 32'h04, 32'h0, rd, rdy);
      bus(1'b1, 32'h0C, 32'h10, rd, rdy);
      @(negedge clk);
      lines[4] = 1'b1; req = 1'b1; we = 1'b1; addr = 32'h00; wdata = 32'h10;
      @(posedge clk);
      @(negedge clk); req = 1'b0; we = 1'b0;
      bus(1'b0, 32'h00, 32'h0, rd, rdy);
      check("D_set_wins", rd, 32'h10);
      @(negedge clk); lines[4] = 1'b0;
      bus(1'b1, 32'h00, 32'h10, rd, rdy);

      // --- E: mask cleared mid-service, ACTIVE readback, reset mid-service ---
      bus(1'b1, 32'h04, 32'h2, rd, rdy);
      @(negedge clk); lines[1] = 1'b1;
      wait_req(10, "E_req");
      check("E_id1", 32'(id), 32'd1);
      bus(1'b1, 32'h04, 32'h0, rd, rdy);
      repeat (5) @(posedge clk);
      #1 check("E_req_held", 32'(irq_req), 32'd1);
      bus(1'b0, 32'h08, 32'h0, rd, rdy);
      check("E_active", rd, 32'h8000_0001);
      @(negedge clk); rst = 1'b1; lines = '0;
      #1 check("E_async_drop", 32'(irq_req), 32'd0);
      @(posedge clk); #1;
      check("E_no_ack", 32'(ack), 32'h0);
      @(negedge clk); rst = 1'b0;
      bus(1'b0, 32'h04, 32'h0, rd, rdy);
      check("E_mask_rst", rd, 32'h0);
      bus(1'b0, 32'h00, 32'h0, rd, rdy);
      check("E_pend_rst", rd, 32'h0);

      // --- Randomized run against the reference model ---
      do_reset();
      m_pend = '0; m_mask = '0; m_hist = '0; m_busy = 0; m_id = 0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         logic [31:0]  e_rd;
         logic [N-1:0] e_ack;
         logic [N-1:0] n_pend;
         int           k;
         @(negedge clk);
         for (int i = 0; i < N; i++) if ($urandom_range(15) == 0) lines[i] = ~lines[i];
         ret   = ($urandom_range(3) == 0);
         req   = ($urandom_range(2) == 0);
         we    = $urandom_range(1);
         wdata = $urandom;
         case ($urandom_range(5))
            0: addr = 32'h00;
            1: addr = 32'h04;
            2: addr = 32'h08;
            3: addr = 32'h0C;
            4: addr = 32'h10;
            default: addr = 32'h3C;
         endcase

         // Read response reflects state before this edge
         e_rd = 32'h0;
         if (req && !we) begin
            if (addr == 32'h00) e_rd = 32'(m_pend);
            if (addr == 32'h04) e_rd = 32'(m_mask);
            if (addr == 32'h08) e_rd = (m_busy ? 32'h8000_0000 : 32'h0) + m_id;
         end
         // Handshake: return acks the source in service; idle picks lowest
         e_ack = '0;
         k = -1;
         if (m_busy) begin
            if (ret) begin
               e_ack[m_id] = 1'b1;
               m_busy = 0;
            end
         end else begin
            for (int i = 0; i < N; i++) begin
               if (m_pend[i] && m_mask[i]) begin
                  k = i;
                  break;
               end
            end
            if (k >= 0) begin
               m_busy = 1;
               m_id   = k;
            end
         end
         // Pending update: any set event beats any clear event
         for (int i = 0; i < N; i++) begin
            bit s, c;
            s = (lines[i] && !m_hist[i]) || (req && we && addr == 32'h0C && wdata[i]);
            c = (req && we && addr == 32'h00 && wdata[i]) || (i == k);
            n_pend[i] = s ? 1'b1 : (c ? 1'b0 : m_pend[i]);
         end
         m_pend = n_pend;
         if (req && we && addr == 32'h04) m_mask = wdata[N-1:0];
         m_hist = lines;

         @(posedge clk); #1;
         check("rand_irq", {irq_req, id, ack}, {10'd0, m_busy, m_id[IW-1:0], e_ack});
         check("rand_ready", 32'(ready), 32'(req));
         if (!(req && we)) check("rand_rdata", rdata, e_rd);
      end
      @(negedge clk); req = 1'b0; we = 1'b0; ret = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog timeout actual=running required=finished");
      $fatal(1);
   end

endmodule
`default_nettype wire
